// File: rtl/hpdcache_flush_walker_pkg.sv
// Shared defaults and width helpers for the flush walker slice.
package hpdcache_flush_walker_pkg;

    localparam int unsigned FW_SETS_DEF  = 64;
    localparam int unsigned FW_WAYS_DEF  = 8;
    localparam int unsigned FW_TAG_W_DEF = 24;

    // Set index width; a single-set cache still needs one bit to carry set 0.
    function automatic int unsigned fw_set_w(input int unsigned sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_flush_walker_if.sv
// Bundles the walker's control, directory and flush-controller signals.
// Signal suffixes are from the walker's point of view.
interface hpdcache_flush_walker_if
    import hpdcache_flush_walker_pkg::*;
#(
    parameter int unsigned SETS  = FW_SETS_DEF,
    parameter int unsigned WAYS  = FW_WAYS_DEF,
    parameter int unsigned TAG_W = FW_TAG_W_DEF
);
    localparam int unsigned SET_W   = fw_set_w(SETS);
    localparam int unsigned NLINE_W = TAG_W + SET_W;

    logic                    start_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    dir_rd_o;
    logic [SET_W-1:0]        dir_rd_set_o;
    logic                    dir_gnt_i;
    logic [WAYS-1:0]         dir_valid_i;
    logic [WAYS-1:0]         dir_dirty_i;
    logic [WAYS*TAG_W-1:0]   dir_tag_i;
    logic                    dir_clr_o;
    logic [SET_W-1:0]        dir_clr_set_o;
    logic [WAYS-1:0]         dir_clr_way_o;
    logic                    flush_alloc_o;
    logic                    flush_alloc_ready_i;
    logic [NLINE_W-1:0]      flush_alloc_nline_o;
    logic [WAYS-1:0]         flush_alloc_way_o;
    logic                    flush_empty_i;

    // Walker side.
    modport master (
        input  start_i, dir_gnt_i, dir_valid_i, dir_dirty_i, dir_tag_i,
               flush_alloc_ready_i, flush_empty_i,
        output busy_o, done_o, dir_rd_o, dir_rd_set_o, dir_clr_o, dir_clr_set_o,
               dir_clr_way_o, flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o
    );

    // Environment side: cache controller, directory and flush controller.
    modport slave (
        output start_i, dir_gnt_i, dir_valid_i, dir_dirty_i, dir_tag_i,
               flush_alloc_ready_i, flush_empty_i,
        input  busy_o, done_o, dir_rd_o, dir_rd_set_o, dir_clr_o, dir_clr_set_o,
               dir_clr_way_o, flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o
    );

endinterface

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Keeps only the lowest-index set bit of the input vector (one-hot or zero).
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            if (gi == 0) begin : g_first
                assign val_o[gi] = val_i[gi];
            end else begin : g_rest
                assign val_o[gi] = val_i[gi] & ~(|val_i[gi-1:0]);
            end
        end
    endgenerate
endmodule

// File: rtl/hpdcache_flush_walker.sv
// Whole-cache flush sequencer: walks every directory set, hands each valid
// dirty line to the flush controller, clears its dirty bit, then waits for
// the flush controller to drain before pulsing done.
module hpdcache_flush_walker
    import hpdcache_flush_walker_pkg::*;
#(
    parameter int unsigned SETS  = FW_SETS_DEF,
    parameter int unsigned WAYS  = FW_WAYS_DEF,
    parameter int unsigned TAG_W = FW_TAG_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    hpdcache_flush_walker_if.master bus
);
    localparam int unsigned    SET_W    = fw_set_w(SETS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    typedef enum logic [2:0] {IDLE, READ, INSPECT, ALLOC, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [SET_W-1:0]        set_q, set_d;
    logic [WAYS-1:0]         pend_q, pend_d;
    logic [WAYS*TAG_W-1:0]   tags_q, tags_d;

    logic [WAYS-1:0]         sel_1h;
    logic [TAG_W-1:0]        sel_tag;
    logic                    last_set;

    logic                    busy, done, dir_rd, dir_clr, alloc;
    logic [SET_W-1:0]        dir_rd_set, dir_clr_set;
    logic [WAYS-1:0]         dir_clr_way, alloc_way;
    logic [TAG_W+SET_W-1:0]  alloc_nline;

    hpdcache_prio_1hot_encoder #(.N(WAYS)) u_sel (
        .val_i (pend_q),
        .val_o (sel_1h)
    );

    assign last_set = (set_q == LAST_SET);

    // Tag of the selected way; sel_1h is one-hot so an AND-OR mux suffices.
    always_comb begin
        sel_tag = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (sel_1h[w]) sel_tag = sel_tag | tags_q[w*TAG_W +: TAG_W];
        end
    end

    // Next-state and outputs; all outputs depend on registered state only,
    // except the clear and done strobes which follow the same-cycle handshakes.
    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        pend_d      = pend_q;
        tags_d      = tags_q;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        dir_rd      = 1'b0;
        dir_rd_set  = '0;
        dir_clr     = 1'b0;
        dir_clr_set = '0;
        dir_clr_way = '0;
        alloc       = 1'b0;
        alloc_nline = '0;
        alloc_way   = '0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    set_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                dir_rd     = 1'b1;
                dir_rd_set = set_q;
                if (bus.dir_gnt_i) state_d = INSPECT;
            end
            INSPECT: begin
                pend_d = bus.dir_valid_i & bus.dir_dirty_i;
                tags_d = bus.dir_tag_i;
                if (|pend_d) begin
                    state_d = ALLOC;
                end else if (last_set) begin
                    state_d = DRAIN;
                end else begin
                    set_d   = set_q + SET_W'(1);
                    state_d = READ;
                end
            end
            ALLOC: begin
                alloc       = 1'b1;
                alloc_nline = {sel_tag, set_q};
                alloc_way   = sel_1h;
                if (bus.flush_alloc_ready_i) begin
                    dir_clr     = 1'b1;
                    dir_clr_set = set_q;
                    dir_clr_way = sel_1h;
                    pend_d      = pend_q & ~sel_1h;
                    if (pend_d == '0) begin
                        if (last_set) begin
                            state_d = DRAIN;
                        end else begin
                            set_d   = set_q + SET_W'(1);
                            state_d = READ;
                        end
                    end
                end
            end
            DRAIN: begin
                if (bus.flush_empty_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, set counter, pending mask and latched tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            pend_q  <= '0;
            tags_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            pend_q  <= pend_d;
            tags_q  <= tags_d;
        end
    end

    assign bus.busy_o              = busy;
    assign bus.done_o              = done;
    assign bus.dir_rd_o            = dir_rd;
    assign bus.dir_rd_set_o        = dir_rd_set;
    assign bus.dir_clr_o           = dir_clr;
    assign bus.dir_clr_set_o       = dir_clr_set;
    assign bus.dir_clr_way_o       = dir_clr_way;
    assign bus.flush_alloc_o       = alloc;
    assign bus.flush_alloc_nline_o = alloc_nline;
    assign bus.flush_alloc_way_o   = alloc_way;

endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Bench for the flush walker: a directory model answers reads one cycle after
// grant, a scoreboard holds the expected allocations for each walk.
module tb_hpdcache_flush_walker;
    import hpdcache_flush_walker_pkg::*;

    localparam int unsigned SETS    = 4;
    localparam int unsigned WAYS    = 4;
    localparam int unsigned TAG_W   = 24;
    localparam int unsigned SET_W   = fw_set_w(SETS);
    localparam int unsigned NLINE_W = TAG_W + SET_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hpdcache_flush_walker_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

    hpdcache_flush_walker #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    // Directory contents and read-port model.
    logic [WAYS-1:0]       valid_m [SETS];
    logic [WAYS-1:0]       dirty_m [SETS];
    logic [WAYS*TAG_W-1:0] tag_m   [SETS];
    logic [SET_W-1:0]      rd_set_q = '0;

    always @(posedge clk) begin
        if (bus.dir_rd_o && bus.dir_gnt_i) rd_set_q <= bus.dir_rd_set_o;
    end

    assign bus.dir_valid_i = valid_m[rd_set_q];
    assign bus.dir_dirty_i = dirty_m[rd_set_q];
    assign bus.dir_tag_i   = tag_m[rd_set_q];

    typedef struct packed {
        logic [NLINE_W-1:0] nline;
        logic [WAYS-1:0]    way;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic clear_dir();
        for (int s = 0; s < int'(SETS); s++) begin
            valid_m[s] = '0;
            dirty_m[s] = '0;
            tag_m[s]   = '0;
        end
    endtask

    task automatic set_line(input int s, input int w, input logic v, input logic d,
                            input logic [TAG_W-1:0] t);
        valid_m[s][w] = v;
        dirty_m[s][w] = d;
        tag_m[s][w*TAG_W +: TAG_W] = t;
    endtask

    // Expected allocation order: ascending set, then ascending way.
    task automatic build_expected();
        exp_t e;
        logic [SET_W-1:0] sidx;
        exp_q.delete();
        for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (valid_m[s][w] && dirty_m[s][w]) begin
                    sidx    = SET_W'(s);
                    e.nline = {tag_m[s][w*TAG_W +: TAG_W], sidx};
                    e.way   = WAYS'(1) << w;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Handshake monitor: scoreboard compare, clear strobe, stall stability.
    initial begin
        exp_t e;
        logic prev_stall = 1'b0;
        logic [NLINE_W-1:0] prev_nline = '0;
        logic [WAYS-1:0]    prev_way = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_alloc_held", 64'(bus.flush_alloc_o), 64'd1);
                    check("stall_nline", 64'(bus.flush_alloc_nline_o), 64'(prev_nline));
                    check("stall_way", 64'(bus.flush_alloc_way_o), 64'(prev_way));
                end
                if (bus.flush_alloc_o && bus.flush_alloc_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("alloc_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("alloc nline=0x%0h way=0x%0h (expected 0x%0h/0x%0h)",
                                 bus.flush_alloc_nline_o, bus.flush_alloc_way_o, e.nline, e.way);
                        check("alloc_nline", 64'(bus.flush_alloc_nline_o), 64'(e.nline));
                        check("alloc_way", 64'(bus.flush_alloc_way_o), 64'(e.way));
                        check("clr_strobe", 64'(bus.dir_clr_o), 64'd1);
                        check("clr_set", 64'(bus.dir_clr_set_o), 64'(e.nline[SET_W-1:0]));
                        check("clr_way", 64'(bus.dir_clr_way_o), 64'(e.way));
                    end
                end else if (bus.dir_clr_o) begin
                    check("clr_without_handshake", 64'd1, 64'd0);
                end
                prev_stall = bus.flush_alloc_o && !bus.flush_alloc_ready_i;
                if (prev_stall) stall_cnt++;
                prev_nline = bus.flush_alloc_nline_o;
                prev_way   = bus.flush_alloc_way_o;
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  64'(bus.busy_o), 64'd0);
        check({name, "_done"},  64'(bus.done_o), 64'd0);
        check({name, "_rd"},    64'({bus.dir_rd_o, bus.dir_rd_set_o}), 64'd0);
        check({name, "_clr"},   64'({bus.dir_clr_o, bus.dir_clr_set_o, bus.dir_clr_way_o}), 64'd0);
        check({name, "_alloc"}, 64'({bus.flush_alloc_o, bus.flush_alloc_nline_o,
                                     bus.flush_alloc_way_o}), 64'd0);
    endtask

    // One flush: start is driven in cycle 0; per-cycle input windows are given
    // as cycle ranges relative to it.
    task automatic run_flush(input string name, input int exp_done,
                             input int rdy_lo_from, input int rdy_lo_to,
                             input int gnt_lo_from, input int gnt_lo_to,
                             input int empty_rise, input int restart_at);
        int done_at  = -1;
        int done_cnt = 0;
        logic busy_dropped = 1'b0;
        for (int i = 0; i <= exp_done + 2; i++) begin
            @(posedge clk);
            #1;
            bus.start_i             = (i == 0) || (i == restart_at);
            bus.flush_alloc_ready_i = !(i >= rdy_lo_from && i <= rdy_lo_to);
            bus.dir_gnt_i           = !(i >= gnt_lo_from && i <= gnt_lo_to);
            bus.flush_empty_i       = (i >= empty_rise);
            @(negedge clk);
            if (i == 1) begin
                check({name, "_first_rd"},  64'(bus.dir_rd_o), 64'd1);
                check({name, "_first_set"}, 64'(bus.dir_rd_set_o), 64'd0);
            end
            if (i >= gnt_lo_from && i <= gnt_lo_to + 1) begin
                check({name, "_gnt_hold_rd"},  64'(bus.dir_rd_o), 64'd1);
                check({name, "_gnt_hold_set"}, 64'(bus.dir_rd_set_o), 64'd1);
            end
            if (i >= 1 && i < exp_done && !bus.busy_o && !busy_dropped) begin
                busy_dropped = 1'b1;
                check({name, "_busy_during_walk"}, 64'd0, 64'd1);
            end
            if (i == exp_done - 1) check({name, "_busy_late"}, 64'(bus.busy_o), 64'd1);
            if (i == exp_done + 1) check({name, "_busy_after"}, 64'(bus.busy_o), 64'd0);
            if (bus.done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        $display("%s: done at cycle %0d (expected %0d), %0d pulse(s), %0d alloc(s) left",
                 name, done_at, exp_done, done_cnt, exp_q.size());
        check({name, "_done_cycle"}, 64'(done_at), 64'(exp_done));
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_allocs_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int s0;
        bit seen;
        bus.start_i             = 1'b0;
        bus.dir_gnt_i           = 1'b1;
        bus.flush_alloc_ready_i = 1'b1;
        bus.flush_empty_i       = 1'b1;
        clear_dir();

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean cache.
        build_expected();
        run_flush("clean", 9, -1, -2, -1, -2, 0, -1);

        // Set 2: ways 1 and 3 valid+dirty; way 0 clean, way 2 dirty but invalid.
        clear_dir();
        set_line(2, 0, 1'b1, 1'b0, 24'hB0);
        set_line(2, 1, 1'b1, 1'b1, 24'hA1);
        set_line(2, 2, 1'b0, 1'b1, 24'hB2);
        set_line(2, 3, 1'b1, 1'b1, 24'hA3);
        build_expected();
        run_flush("dirty_set2", 11, -1, -2, -1, -2, 0, -1);

        // Same walk with the flush controller stalled for 5 cycles.
        build_expected();
        s0 = stall_cnt;
        run_flush("stall_set2", 16, 7, 11, -1, -2, 0, -1);
        check("stall_cycles", 64'(stall_cnt - s0), 64'd5);

        // Clean cache, grant withheld during the read of set 1.
        clear_dir();
        build_expected();
        run_flush("gnt_stall", 12, -1, -2, 3, 5, 0, -1);

        // Last set dirty, slow drain, extra start pulse mid-walk.
        set_line(3, 0, 1'b1, 1'b1, 24'hC0);
        set_line(3, 2, 1'b1, 1'b1, 24'hC2);
        build_expected();
        run_flush("drain_wait", 21, -1, -2, -1, -2, 21, 4);

        // Reset while stuck in ALLOC, then restart from set 0.
        clear_dir();
        set_line(1, 0, 1'b1, 1'b1, 24'hD0);
        set_line(1, 1, 1'b1, 1'b1, 24'hD1);
        set_line(1, 2, 1'b1, 1'b1, 24'hD2);
        build_expected();
        @(posedge clk);
        #1;
        bus.start_i             = 1'b1;
        bus.flush_alloc_ready_i = 1'b0;
        bus.flush_empty_i       = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.flush_alloc_o;
        end
        check("rst_reached_alloc", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        build_expected();
        run_flush("after_reset", 12, -1, -2, -1, -2, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
